// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] MTYPE_FUNCT7 = 7'b0000001;
   localparam logic [2:0] ALUOP_MTYPE  = 3'b011;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline and the M-extension sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is driven by the sequencer and freezes the upstream stages.
interface muldiv_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   // pipeline side
   modport master (
      output start, funct3, rs1_val, rs2_val, flush,
      input  stall, done, result
   );

   // sequencer side
   modport slave (
      input  start, funct3, rs1_val, rs2_val, flush,
      output stall, done, result
   );
endinterface

// File: rtl/muldiv_sequencer_div_step.sv
// One radix-2 restoring division step on the {rem,quo} pair.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] dvs,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);
   // rem < dvs always holds, so the shifted remainder minus dvs fits in XLEN+1
   // bits and its top bit is a clean borrow flag.
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   assign rem_sh = {rem_in, quo_in[XLEN-1]};
   assign diff   = rem_sh - {1'b0, dvs};

   // restore on borrow, otherwise keep the difference and shift in a 1
   always_comb begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
      if (diff[XLEN]) begin
         rem_out = rem_sh[XLEN-1:0];
         quo_out = {quo_in[XLEN-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M EX-stage sequencer: registered multiplier plus iterative restoring divider.
// Latency: MUL* 2 cycles start->done, DIV/REM 34, divide-by-zero/overflow 1.
// Backpressure: stall holds IF/ID/EX while busy; MULDIV_DIVREM_FUSE_EN adds a 1-cycle DIV/REM result cache.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic               clk,
   input logic               rst,
   muldiv_sequencer_if.slave bus
);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state;
   logic [CNT_W-1:0]  counter;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   dvs;
   logic              neg_q;
   logic              neg_r;
   logic [1:0]        op_sel;
   logic [XLEN:0]     op_a;
   logic [XLEN:0]     op_b;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   // decode of the instruction presented in IDLE
   logic            a_signed;
   logic            b_signed;
   logic            div_signed;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;

   assign a_signed   = (bus.funct3 != F3_MULHU);
   assign b_signed   = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH);
   assign div_signed = (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
   assign div_zero   = (bus.rs2_val == '0);
   assign div_ovf    = div_signed && (bus.rs1_val == INT_MIN) && (bus.rs2_val == '1);
   assign abs_a      = (div_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
   assign abs_b      = (div_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;

   // The signed 33x33 product needs 66 bits, but its top two bits are only sign
   // copies, so the low 2*XLEN bits of a sign-extended multiply carry everything.
   logic [2*XLEN-1:0] wide_a;
   logic [2*XLEN-1:0] wide_b;
   logic [2*XLEN-1:0] mul_prod;
   logic [XLEN-1:0]   mul_res;

   assign wide_a   = {{(XLEN-1){op_a[XLEN]}}, op_a};
   assign wide_b   = {{(XLEN-1){op_b[XLEN]}}, op_b};
   assign mul_prod = wide_a * wide_b;
   assign mul_res  = (op_sel == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

   // divider datapath
   logic [XLEN-1:0] step_rem;
   logic [XLEN-1:0] step_quo;
   logic [XLEN-1:0] fix_quo;
   logic [XLEN-1:0] fix_rem;

   div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .dvs     (dvs),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   assign fix_quo = neg_q ? -quo : quo;
   assign fix_rem = neg_r ? -rem : rem;

`ifdef MULDIV_DIVREM_FUSE_EN
   logic            c_vld;
   logic            c_sgn;
   logic [XLEN-1:0] c_a;
   logic [XLEN-1:0] c_b;
   logic [XLEN-1:0] c_quo;
   logic [XLEN-1:0] c_rem;
   logic [XLEN-1:0] raw_a;
   logic [XLEN-1:0] raw_b;
   logic            raw_sgn;
   logic            cache_hit;

   assign cache_hit = c_vld && (c_a == bus.rs1_val) && (c_b == bus.rs2_val) &&
                      (c_sgn == div_signed);
`endif

   assign bus.stall  = ((state == IDLE) && bus.start && !bus.flush) ||
                       (state == MUL) || (state == DIV) || (state == FIX);
   assign bus.done   = done_q;
   assign bus.result = result_q;

   // sequencer FSM with registered done/result; flush outranks start and completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         counter  <= '0;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         op_sel   <= 2'b00;
         op_a     <= '0;
         op_b     <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
`ifdef MULDIV_DIVREM_FUSE_EN
         c_vld    <= 1'b0;
         c_sgn    <= 1'b0;
         c_a      <= '0;
         c_b      <= '0;
         c_quo    <= '0;
         c_rem    <= '0;
         raw_a    <= '0;
         raw_b    <= '0;
         raw_sgn  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= IDLE;
`ifdef MULDIV_DIVREM_FUSE_EN
            if ((state == DIV) || (state == FIX)) c_vld <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     op_sel <= bus.funct3[1:0];
                     if (!bus.funct3[2]) begin
                        op_a  <= {a_signed & bus.rs1_val[XLEN-1], bus.rs1_val};
                        op_b  <= {b_signed & bus.rs2_val[XLEN-1], bus.rs2_val};
                        state <= MUL;
                     end else if (div_zero) begin
                        quo      <= '1;
                        rem      <= bus.rs1_val;
                        result_q <= bus.funct3[1] ? bus.rs1_val : '1;
                        done_q   <= 1'b1;
                        state    <= DONE;
`ifdef MULDIV_DIVREM_FUSE_EN
                        c_vld    <= 1'b0;
`endif
                     end else if (div_ovf) begin
                        quo      <= INT_MIN;
                        rem      <= '0;
                        result_q <= bus.funct3[1] ? '0 : INT_MIN;
                        done_q   <= 1'b1;
                        state    <= DONE;
`ifdef MULDIV_DIVREM_FUSE_EN
                        c_vld    <= 1'b0;
`endif
`ifdef MULDIV_DIVREM_FUSE_EN
                     end else if (cache_hit) begin
                        quo      <= c_quo;
                        rem      <= c_rem;
                        result_q <= bus.funct3[1] ? c_rem : c_quo;
                        done_q   <= 1'b1;
                        state    <= DONE;
`endif
                     end else begin
                        quo     <= abs_a;
                        rem     <= '0;
                        dvs     <= abs_b;
                        neg_q   <= div_signed && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
                        neg_r   <= div_signed && bus.rs1_val[XLEN-1];
                        counter <= CNT_W'(XLEN);
                        state   <= DIV;
`ifdef MULDIV_DIVREM_FUSE_EN
                        raw_a   <= bus.rs1_val;
                        raw_b   <= bus.rs2_val;
                        raw_sgn <= div_signed;
`endif
                     end
                  end
               end
               MUL: begin
                  result_q <= mul_res;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end
               DIV: begin
                  quo     <= step_quo;
                  rem     <= step_rem;
                  counter <= counter - CNT_W'(1);
                  if (counter == CNT_W'(1)) state <= FIX;
               end
               FIX: begin
                  quo      <= fix_quo;
                  rem      <= fix_rem;
                  result_q <= op_sel[1] ? fix_rem : fix_quo;
                  done_q   <= 1'b1;
                  state    <= DONE;
`ifdef MULDIV_DIVREM_FUSE_EN
                  c_vld    <= 1'b1;
                  c_a      <= raw_a;
                  c_b      <= raw_b;
                  c_sgn    <= raw_sgn;
                  c_quo    <= fix_quo;
                  c_rem    <= fix_rem;
`endif
               end
               // start is still the same instruction here, so it is not re-accepted
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus flush/reset/cache sequences.
// Latency: checks start->done cycle counts and stall duration per operation.
// Backpressure: holds start while stall is high, as the pipeline would.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.XLEN(32)) bus ();

   muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];
   logic [31:0] last_exp;

   // reference model of the divide result cache
   bit          c_vld = 1'b0;
   logic [31:0] c_a, c_b;
   bit          c_s;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return 2;
      if (b == 32'h0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_DIVREM_FUSE_EN
      if (c_vld && c_a == a && c_b == b && c_s == !f3[0]) return 1;
`endif
      return 34;
   endfunction

   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat, cyc, stalls;
      bit seen;
      lat = exp_lat(f3, a, b);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.funct3  = f3;
      bus.rs1_val = a;
      bus.rs2_val = b;
      sb.push_back(exp);
      #1;
      cyc = 0; stalls = 0; seen = 1'b0;
      while (!seen && cyc < 100) begin
         if (bus.stall) stalls++;
         if (bus.done) begin
            seen = 1'b1;
            check({name, "/result"}, bus.result, sb.pop_front());
            check({name, "/latency"}, 32'(cyc), 32'(lat));
         end else begin
            @(negedge clk);
            #1;
            cyc++;
         end
      end
      bus.start = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s/timeout: no done after %0d cycles, expected done at %0d", name, cyc, lat);
         void'(sb.pop_front());
      end else begin
         check({name, "/stall_cycles"}, 32'(stalls), 32'(lat));
         @(negedge clk);
         #1;
         check({name, "/done_pulse"}, {31'b0, bus.done}, 32'h0);
      end
      last_exp = exp;
      if (f3[2]) begin
         if (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) c_vld = 1'b0;
         else begin c_vld = 1'b1; c_a = a; c_b = b; c_s = !f3[0]; end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      vecs[0]  = '{"mul_7x-3",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{"mulhu_max",     F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{"mulhsu_max",    F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3]  = '{"mulh_-1x-1",    F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[4]  = '{"div_-20/3",     F3_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA};
      vecs[5]  = '{"rem_-20/3",     F3_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE};
      vecs[6]  = '{"divu_5/0",      F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
      vecs[7]  = '{"rem_5/0",       F3_REM,    32'd5,          32'd0,         32'd5};
      vecs[8]  = '{"div_ovf",       F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[9]  = '{"rem_ovf",       F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[10] = '{"divu_100/7",    F3_DIVU,   32'd100,        32'd7,         32'd14};
      vecs[11] = '{"remu_big/16",   F3_REMU,   32'hFFFF_FFFF,  32'd16,        32'd15};
      vecs[12] = '{"div_7/-2",      F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};

      rst = 1'b1;
      bus.start = 1'b0; bus.funct3 = 3'b000; bus.rs1_val = '0; bus.rs2_val = '0; bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset/stall", {31'b0, bus.stall}, 32'h0);
      check("reset/done", {31'b0, bus.done}, 32'h0);
      check("reset/result", bus.result, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
      run_op("rem_7/-2", F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);

      // flush in the middle of a divide
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = F3_DIV; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7;
      repeat (10) @(negedge clk);
      #1;
      check("flush/stall_before", {31'b0, bus.stall}, 32'h1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0; bus.start = 1'b0;
      #1;
      check("flush/stall_after", {31'b0, bus.stall}, 32'h0);
      check("flush/done", {31'b0, bus.done}, 32'h0);
      check("flush/result_kept", bus.result, last_exp);
      c_vld = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check("flush/no_done", 32'(ndone), 32'h0);
      run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12);

      // reset in the middle of a divide
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = F3_DIV; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7;
      repeat (5) @(negedge clk);
      rst = 1'b1; bus.start = 1'b0;
      #1;
      check("midrst/stall", {31'b0, bus.stall}, 32'h0);
      check("midrst/done", {31'b0, bus.done}, 32'h0);
      check("midrst/result", bus.result, 32'h0);
      c_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // back-to-back DIV/REM on identical operands
      run_op("div_100/7", F3_DIV, 32'd100, 32'd7, 32'd14);
      run_op("rem_100/7", F3_REM, 32'd100, 32'd7, 32'd2);

      check("scoreboard/empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
